// File: rtl/parity_serializer.sv
// Serial parity link transmitter: shifts a WIDTH-bit word out LSB-first,
// then appends one parity bit (even when ODD=0, odd when ODD=1).
module parity_serializer #(
  parameter int unsigned WIDTH = 3,
  parameter bit          ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             par_flag,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [CW-1:0]     cnt;
  logic              par;

  // ser_out is loaded one edge ahead with the bit about to be presented, so
  // every output is a plain flop and nothing is decoded from the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      par_flag  <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= data_in;
            par       <= (^data_in) ^ ODD;
            cnt       <= '0;
            ser_out   <= data_in[0];
            ser_valid <= 1'b1;
            ready     <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            ser_out  <= par;
            par_flag <= 1'b1;
            state    <= PARITY;
          end else begin
            cnt     <= cnt + 1'b1;
            ser_out <= shift_reg[1];
          end
        end
        PARITY: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          par_flag  <= 1'b0;
          ready     <= 1'b1;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          par_flag  <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer: one even-parity and one odd-parity
// instance, WIDTH=3, expected streams hand-computed per frame.
module tb_parity_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] data0 = '0, data1 = '0;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic       rdy0, so0, sv0, pf0, dn0;
  logic       rdy1, so1, sv1, pf1, dn1;
  logic       sel = 1'b0;
  logic       rdy, so, sv, pf, dn;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  parity_serializer #(.WIDTH(3), .ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data0), .load(load0),
    .ready(rdy0), .ser_out(so0), .ser_valid(sv0), .par_flag(pf0), .done(dn0)
  );

  parity_serializer #(.WIDTH(3), .ODD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data1), .load(load1),
    .ready(rdy1), .ser_out(so1), .ser_valid(sv1), .par_flag(pf1), .done(dn1)
  );

  assign rdy = sel ? rdy1 : rdy0;
  assign so  = sel ? so1  : so0;
  assign sv  = sel ? sv1  : sv0;
  assign pf  = sel ? pf1  : pf0;
  assign dn  = sel ? dn1  : dn0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [2:0] d);
    if (sel) begin load1 = ld; data1 = d; end
    else     begin load0 = ld; data0 = d; end
  endtask

  // Called in the first data cycle; returns in the done cycle.
  // exp = {parity, d2, d1, d0}. poke pulses a load with 3'b010 mid-frame.
  task automatic frame_check(input string tag, input logic [3:0] exp,
                             input bit poke, output logic [3:0] got);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_valid"}, sv, 1'b1);
      check({tag, "_ready"}, rdy, 1'b0);
      check({tag, "_pflag"}, pf, 1'b0);
      check({tag, "_bit"}, so, exp[i]);
      got[i] = so;
      if (poke && i == 0) drive(1'b1, 3'b010);
      tick();
      if (poke && i == 0) drive(1'b0, 3'b010);
    end
    check({tag, "_pvalid"}, sv, 1'b1);
    check({tag, "_pflag"}, pf, 1'b1);
    check({tag, "_par"}, so, exp[3]);
    got[3] = so;
    tick();
    check({tag, "_done"}, dn, 1'b1);
    check({tag, "_rdy_done"}, rdy, 1'b1);
    check({tag, "_sv_done"}, sv, 1'b0);
  endtask

  task automatic send(input string tag, input logic [2:0] w, input logic [3:0] exp);
    logic [3:0] got;
    drive(1'b1, w);
    tick();
    drive(1'b0, w);
    frame_check(tag, exp, 1'b0, got);
    tick();
    check({tag, "_done_off"}, dn, 1'b0);
  endtask

  initial begin
    logic [3:0] got;
    logic [3:0] exp;

    #12;
    check("rst_ready0", rdy0, 1'b1);
    check("rst_out0", {so0, sv0, pf0, dn0}, 4'b0000);
    check("rst_out1", {rdy1, so1, sv1, pf1, dn1}, 5'b10000);
    reset = 1'b1;
    tick();

    sel = 1'b0;
    send("e101", 3'b101, 4'b0101);
    send("e111", 3'b111, 4'b1111);
    sel = 1'b1;
    send("o000", 3'b000, 4'b1000);

    // back-to-back frames with load held, both parities
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      drive(1'b1, 3'd0);
      tick();
      for (int w = 0; w < 8; w++) begin
        logic [2:0] wv;
        wv = 3'(w);
        drive(1'b1, 3'(w + 1));
        exp = {(^wv) ^ sel, wv};
        frame_check(sel ? "exh_o" : "exh_e", exp, 1'b0, got);
        check("exh_xor", ^got, sel);
        check("exh_data", got[2:0], wv);
        if (w == 7) drive(1'b0, 3'd0);
        tick();
      end
      check("exh_stop", sv, 1'b0);
      tick();
    end

    // load during SHIFT is ignored
    sel = 1'b0;
    drive(1'b1, 3'b110);
    tick();
    drive(1'b0, 3'b110);
    frame_check("ign", 4'b0110, 1'b1, got);
    tick();
    check("ign_no2nd_sv", sv, 1'b0);
    check("ign_no2nd_rdy", rdy, 1'b1);
    tick();
    check("ign_no2nd_sv2", sv, 1'b0);

    // asynchronous reset in the second data bit
    drive(1'b1, 3'b101);
    tick();
    drive(1'b0, 3'b101);
    tick();
    check("mid_sv_pre", sv, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_sv", sv, 1'b0);
    check("mid_rst_so", so, 1'b0);
    check("mid_rst_rdy", rdy, 1'b1);
    tick();
    check("mid_rst_done", dn, 1'b0);
    tick();
    reset = 1'b1;
    check("mid_rel_done", dn, 1'b0);
    check("mid_rel_rdy", rdy, 1'b1);
    send("after_rst", 3'b001, 4'b1001);

    // data_in wiggled after acceptance must not leak into the frame
    drive(1'b1, 3'b100);
    tick();
    drive(1'b0, 3'b011);
    check("samp_b0", so, 1'b0);
    tick();
    drive(1'b0, 3'b111);
    check("samp_b1", so, 1'b0);
    tick();
    drive(1'b0, 3'b000);
    check("samp_b2", so, 1'b1);
    tick();
    drive(1'b0, 3'b010);
    check("samp_par", {pf, so}, 2'b11);
    tick();
    check("samp_done", dn, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
